// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
package gmii_tx_arb_pkg;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN, GAP} state_t;

  localparam int IFG_DEFAULT     = 12;
  localparam int MAX_LEN_DEFAULT = 1514;

  // Bits needed to index n items; never returns 0 so single-entry vectors stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// Requester-side and MAC-side byte streams of the GMII transmit arbiter.
interface gmii_tx_arbiter_if #(parameter int NUM_REQ = 2);
  import gmii_tx_arb_pkg::*;

  localparam int SRC_W = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_last;
  logic                 out_ready;
  logic [SRC_W-1:0]     out_src;
  logic                 out_abort;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, out_abort, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, out_abort, busy
  );

endinterface

// File: rtl/gmii_tx_arbiter_pick.sv
// Combinational winner selection; round-robin by default, lowest index wins
// when TX_ARB_FIXED_PRIO_EN is defined.
module tx_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int SRC_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   last_grant,
  output logic [SRC_W-1:0]   winner,
  output logic               any
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;

  always_comb begin
    any    = |req;
    winner = '0;
    mask   = '0;
    masked = '0;
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) winner = SRC_W'(i);
`else
    // Requests strictly above last_grant take precedence; otherwise wrap to the lowest.
    for (int i = 0; i < NUM_REQ; i++) mask[i] = (i > int'(last_grant));
    masked = req & mask;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) winner = SRC_W'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (masked[i]) winner = SRC_W'(i);
`endif
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Frame-granular arbiter sharing one GMII TX MAC among NUM_REQ byte streams.
// Define TX_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module gmii_tx_arbiter
  import gmii_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = IFG_DEFAULT,
  parameter int MAX_LEN    = MAX_LEN_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  gmii_tx_arbiter_if.slave  bus
);

  localparam int SRC_W = clog2_min1(NUM_REQ);
  localparam int CNT_W = clog2_min1(MAX_LEN + 1);
  localparam int GAP_W = clog2_min1(IFG_CYCLES);

  state_t           state, state_nx;
  logic [SRC_W-1:0] grant, last_grant, winner;
  logic             any;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             accept, underrun, overflow;
  logic             abort_p1;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;

  tx_arb_pick #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W)) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any)
  );

  assign sel_valid = bus.req_valid[grant];
  assign sel_last  = bus.req_last[grant];
  assign sel_data  = bus.req_data[{grant, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(NUM_REQ - 1);
      cnt        <= '0;
      gap_cnt    <= '0;
      abort_p1   <= 1'b0;
    end else begin
      state    <= state_nx;
      abort_p1 <= underrun | overflow;
      if (state == IDLE && any) begin
        grant      <= winner;
        last_grant <= winner;
        cnt        <= '0;
      end else if (accept && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.req_ready = '0;
    accept        = 1'b0;
    underrun      = 1'b0;
    overflow      = 1'b0;
    unique case (state)
      IDLE: if (any) state_nx = PASS;
      PASS: begin
        bus.out_valid        = sel_valid;
        bus.out_data         = sel_data;
        bus.req_ready[grant] = bus.out_ready;
        accept   = bus.out_ready & sel_valid;
        underrun = bus.out_ready & ~sel_valid;
        // Byte MAX_LEN without last: close it towards the MAC and drop the rest.
        overflow = accept & ~sel_last & (cnt == CNT_W'(MAX_LEN - 1));
        bus.out_last = sel_last | overflow;
        if (accept && sel_last)      state_nx = GAP;
        else if (underrun || overflow) state_nx = DRAIN;
      end
      DRAIN: begin
        bus.req_ready[grant] = 1'b1;
        if (sel_valid && sel_last) state_nx = GAP;
      end
      GAP: if (gap_cnt == GAP_W'(IFG_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.out_src   = grant;
  assign bus.out_abort = abort_p1;
  assign bus.busy      = (state != IDLE);

endmodule
